// File: rtl/pipe_csel_addsub_pkg.sv
// Shared defaults and helpers for the pipelined carry-select adder/subtractor.
package pipe_csel_addsub_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_BLK    = 4;
    localparam int DEF_STAGES = 2;

    function automatic int stage_bits(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_csel_addsub_csel_block.sv
// BLK-wide carry-select cell: two ripple chains (carry-in 0 and 1), output picked by the real carry.
module csel_block
    import pipe_csel_addsub_pkg::*;
#(
    parameter int BLK = DEF_BLK
) (
    input  logic [BLK-1:0] a_i,
    input  logic [BLK-1:0] b_i,
    input  logic           c_i,
    output logic [BLK-1:0] s_o,
    output logic           c_o
);

    logic [BLK-1:0] s0, s1;
    logic [BLK:0]   r0, r1;

    always_comb begin
        s0    = '0;
        s1    = '0;
        r0    = '0;
        r1    = '0;
        r1[0] = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            s0[i]   = a_i[i] ^ b_i[i] ^ r0[i];
            r0[i+1] = (a_i[i] & b_i[i]) | (r0[i] & (a_i[i] ^ b_i[i]));
            s1[i]   = a_i[i] ^ b_i[i] ^ r1[i];
            r1[i+1] = (a_i[i] & b_i[i]) | (r1[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign s_o = c_i ? s1 : s0;
    assign c_o = c_i ? r1[BLK] : r0[BLK];

endmodule

// File: rtl/pipe_csel_addsub.sv
// Pipelined add/subtract: each stage resolves WIDTH/STAGES bits with carry-select blocks,
// registering its carry plus the untouched upper operands and finished lower sum bits.
module pipe_csel_addsub
    import pipe_csel_addsub_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int BLK    = DEF_BLK,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW   = stage_bits(WIDTH, STAGES);
    localparam int NBLK = SW / BLK;

    // One global enable: every stage advances together or the whole pipe holds.
    assign in_ready = !out_valid || out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * SW;
        localparam int UW = WIDTH - LO;

        logic [UW-1:0]    a_in, b_in;
        logic             c_in, v_in;
        logic [SW-1:0]    s_slice;
        logic [NBLK:0]    cy;
        logic [LO+SW-1:0] s_d, s_q;
        logic             v_q, c_q;

        if (k == 0) begin : g_src
            assign a_in = a;
            assign b_in = b ^ {WIDTH{sub}};
            assign c_in = sub | cin;
            assign v_in = in_valid;
            assign s_d  = s_slice;
        end else begin : g_src
            assign a_in = g_stg[k-1].g_up.a_q;
            assign b_in = g_stg[k-1].g_up.b_q;
            assign c_in = g_stg[k-1].c_q;
            assign v_in = g_stg[k-1].v_q;
            assign s_d  = {s_slice, g_stg[k-1].s_q};
        end

        assign cy[0] = c_in;

        for (genvar j = 0; j < NBLK; j++) begin : g_blk
            csel_block #(.BLK(BLK)) u_blk (
                .a_i (a_in[j*BLK +: BLK]),
                .b_i (b_in[j*BLK +: BLK]),
                .c_i (cy[j]),
                .s_o (s_slice[j*BLK +: BLK]),
                .c_o (cy[j+1])
            );
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (in_ready) begin
                v_q <= v_in;
                c_q <= cy[NBLK];
                s_q <= s_d;
            end
        end

        if (k < STAGES - 1) begin : g_up
            logic [UW-SW-1:0] a_q, b_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (in_ready) begin
                    a_q <= a_in[UW-1:SW];
                    b_q <= b_in[UW-1:SW];
                end
            end
        end else begin : g_last
            logic ovf_d, ovf_q;

            // Carry into the MSB is recovered from that bit's own sum: a ^ b ^ s.
            assign ovf_d = a_in[UW-1] ^ b_in[UW-1] ^ s_slice[SW-1] ^ cy[NBLK];

            always_ff @(posedge clk or posedge reset) begin
                if (reset)         ovf_q <= 1'b0;
                else if (in_ready) ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].v_q;
    assign sum       = g_stg[STAGES-1].s_q;
    assign cout      = g_stg[STAGES-1].c_q;
    assign ovf       = g_stg[STAGES-1].g_last.ovf_q;

endmodule
